// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding, default sizes and block types for the memory arbiter.
package mem_arb_pkg;
  localparam int NUM_CH_DEF = 4;
  localparam int ADDR_W_DEF = 64;
  localparam int BLOCK_W_DEF = 512;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;
  typedef logic [$clog2(NUM_CH_DEF)-1:0] ch_idx_t;
  typedef logic [BLOCK_W_DEF-1:0] block_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: combinational pick of the first request at or after ptr_i, wrapping to 0.
module rr_priority_picker #(
  parameter int NUM_CH = 4,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IW-1:0]     ptr_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IW-1:0]     idx_o,
  output logic              any_o
);
  int j;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    j = 0;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = int'(ptr_i) + i;
      j = (j >= NUM_CH) ? j - NUM_CH : j;
      if (req_i[j]) begin
        gnt_o = '0;
        gnt_o[j] = 1'b1;
        idx_o = IW'(j);
      end
    end
    any_o = |req_i;
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin (or fixed-priority) arbiter of N cache channels onto one memory port,
// one block transfer in flight at a time.
module mem_arbiter_rr import mem_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int BLOCK_W = BLOCK_W_DEF,
  parameter bit FIXED_PRI = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_wr_en,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH*BLOCK_W-1:0] ch_wdata,
  output logic [BLOCK_W-1:0]        ch_rdata,
  output logic [NUM_CH-1:0]         ch_complete,
  output logic                      mem_req,
  output logic                      mem_wr_en,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [BLOCK_W-1:0]        mem_data_out,
  input  logic [BLOCK_W-1:0]        mem_data_in,
  input  logic                      mem_data_valid
);
  localparam int IW = $clog2(NUM_CH);
  arb_state_e state_q, state_d;
  logic [IW-1:0] rr_ptr_q, grant_q, pick_idx;
  logic [NUM_CH-1:0] gnt_oh_q, pick_oh;
  logic pick_any, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BLOCK_W-1:0] wdata_q, rdata_q;
  rr_priority_picker #(.NUM_CH(NUM_CH)) u_picker (
    .req_i (ch_req),
    .ptr_i (FIXED_PRI ? IW'(0) : rr_ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = pick_any ? BUSY : IDLE;
      BUSY:    state_d = mem_data_valid ? DONE : BUSY;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_req = state_q == BUSY;
    ch_complete = (state_q == DONE) ? gnt_oh_q : '0;
    mem_wr_en = wr_q;
    mem_address = addr_q;
    mem_data_out = wdata_q;
    ch_rdata = rdata_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= '0;
      grant_q <= '0;
      gnt_oh_q <= '0;
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (state_q == IDLE && pick_any) begin
      grant_q <= pick_idx;
      gnt_oh_q <= pick_oh;
      wr_q <= ch_wr_en[pick_idx];
      addr_q <= ch_addr[pick_idx*ADDR_W +: ADDR_W];
      wdata_q <= ch_wdata[pick_idx*BLOCK_W +: BLOCK_W];
    end else if (state_q == BUSY && mem_data_valid) begin
      // Write acks leave the last read block visible to the channels.
      rdata_q <= wr_q ? rdata_q : mem_data_in;
      rr_ptr_q <= (grant_q == IW'(NUM_CH - 1)) ? '0 : grant_q + 1'b1;
    end
  end
endmodule
